// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared pipeline-control types and constants for hazard and forwarding logic
package core_ctrl_pkg;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
// ports: clk, rst_n (async active-low), inc (count one), clear (sync zero), value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clear) value <= '0;
    else if (inc && value != '1) value <= value + W'(1);
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch squash and data-memory freeze sequencing
// ports: IFID/IDEX register fields and branch/dmem handshakes in; PC and pipeline-register
//        write enables, IF/ID and ID/EX flushes, saturating stall/flush counts and a
//        sticky memory-timeout flag out
module hazard_stall_controller
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFIDrs1,
  input  logic [4:0]       IFIDrs2,
  input  logic             IFIDusesRs2,
  input  logic             IDEXmemRead,
  input  logic [4:0]       IDEXrd,
  input  logic             branchTaken,
  input  logic             dmemReq,
  input  logic             dmemReady,
  output logic             PCwrite,
  output logic             IFIDwrite,
  output logic             IDEXwrite,
  output logic             EXMEMwrite,
  output logic             IFIDflush,
  output logic             IDEXflush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             memTimeoutErr
);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        load_use, stall_inc, flush_inc;
  logic        pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl;
  assign load_use = IDEXmemRead && IDEXrd != REG_ZERO &&
                    (IDEXrd == IFIDrs1 || (IFIDusesRs2 && IDEXrd == IFIDrs2));
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state == MEM_WAIT || (dmemReq && !dmemReady)) begin
      {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
      stall_inc = 1'b1;
      if (state == RUN) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = 16'd1;
      end else if (dmemReady) state_nxt = RUN;
      else wait_nxt = (wait_cnt >= TO) ? TO : wait_cnt + 16'd1;
    end else if (branchTaken) begin
      ifid_fl   = 1'b1;
      idex_fl   = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_fl   = 1'b1;
      stall_inc = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= RUN;
      wait_cnt      <= '0;
      memTimeoutErr <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == MEM_WAIT && wait_nxt == TO) memTimeoutErr <= 1'b1;
    end
  // Outputs are forced to the free-running pattern while reset is held, whatever the inputs.
  assign PCwrite    = !rst_n || pc_we;
  assign IFIDwrite  = !rst_n || ifid_we;
  assign IDEXwrite  = !rst_n || idex_we;
  assign EXMEMwrite = !rst_n || exmem_we;
  assign IFIDflush  = rst_n && ifid_fl;
  assign IDEXflush  = rst_n && idex_fl;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst_n), .inc(stall_inc), .clear(1'b0), .value(stallCount)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst_n(rst_n), .inc(flush_inc), .clear(1'b0), .value(flushCount)
  );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed bench with a cycle model and literal pins
module tb_hazard_stall_controller;
  localparam int CW = 4, TO = 4, MAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n;
  logic [4:0] IFIDrs1, IFIDrs2, IDEXrd;
  logic IFIDusesRs2, IDEXmemRead, branchTaken, dmemReq, dmemReady;
  logic PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, IFIDflush, IDEXflush, memTimeoutErr;
  logic [CW-1:0] stallCount, flushCount;
  logic [5:0] ctrl;
  int total = 0, bad = 0;
  bit m_wait, m_err;
  int m_wc, m_stall, m_flush;
  always #5 clk = ~clk;
  hazard_stall_controller #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2), .IFIDusesRs2(IFIDusesRs2),
    .IDEXmemRead(IDEXmemRead), .IDEXrd(IDEXrd), .branchTaken(branchTaken), .dmemReq(dmemReq),
    .dmemReady(dmemReady), .PCwrite(PCwrite), .IFIDwrite(IFIDwrite), .IDEXwrite(IDEXwrite),
    .EXMEMwrite(EXMEMwrite), .IFIDflush(IFIDflush), .IDEXflush(IDEXflush),
    .stallCount(stallCount), .flushCount(flushCount), .memTimeoutErr(memTimeoutErr)
  );
  assign ctrl = {PCwrite, IFIDwrite, IDEXwrite, EXMEMwrite, IFIDflush, IDEXflush};
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic bit lu();
    return IDEXmemRead && IDEXrd != 0 &&
           (IDEXrd == IFIDrs1 || (IFIDusesRs2 && IDEXrd == IFIDrs2));
  endfunction
  function automatic bit frozen();
    return m_wait || (dmemReq && !dmemReady);
  endfunction
  function automatic logic [5:0] exp_ctrl();
    if (!rst_n) return 6'b111100;
    if (frozen()) return 6'b000000;
    if (branchTaken) return 6'b111111;
    if (lu()) return 6'b001101;
    return 6'b111100;
  endfunction
  function automatic int sat(input int v);
    return v > MAX ? MAX : v;
  endfunction
  always @(negedge clk) begin
    chk("model_ctrl", int'(ctrl), int'(exp_ctrl()));
    chk("model_stall", int'(stallCount), m_stall);
    chk("model_flush", int'(flushCount), m_flush);
    chk("model_err", int'(memTimeoutErr), int'(m_err));
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_wait <= 0; m_wc <= 0; m_stall <= 0; m_flush <= 0; m_err <= 0;
    end else begin
      if (frozen()) m_stall <= sat(m_stall + 1);
      else if (branchTaken) m_flush <= sat(m_flush + 1);
      else if (lu()) m_stall <= sat(m_stall + 1);
      if (m_wait) begin
        if (dmemReady) m_wait <= 0;
        else begin
          m_wc <= (m_wc + 1 > TO) ? TO : m_wc + 1;
          if (m_wc + 1 >= TO) m_err <= 1;
        end
      end else if (dmemReq && !dmemReady) begin
        m_wait <= 1;
        m_wc <= 1;
        if (TO <= 1) m_err <= 1;
      end
    end
  initial begin
    {IFIDrs1, IFIDrs2, IDEXrd} = '0;
    {IFIDusesRs2, IDEXmemRead, branchTaken, dmemReady} = '0;
    rst_n = 0; dmemReq = 1;
    @(negedge clk); chk("rst_ctrl", int'(ctrl), 6'b111100); chk("rst_stall", int'(stallCount), 0);
    cyc(); rst_n = 1; dmemReq = 0;
    IDEXmemRead = 1; IDEXrd = 5; IFIDrs1 = 5;
    @(negedge clk); chk("lu_ctrl", int'(ctrl), 6'b001101);
    cyc(); IDEXmemRead = 0;
    @(negedge clk); chk("lu_after", int'(ctrl), 6'b111100); chk("lu_stall", int'(stallCount), 1);
    cyc(); IDEXmemRead = 1; IDEXrd = 0; IFIDrs1 = 0;
    @(negedge clk); chk("x0_ctrl", int'(ctrl), 6'b111100);
    cyc(); IDEXrd = 7; IFIDrs1 = 1; IFIDrs2 = 7; IFIDusesRs2 = 0;
    @(negedge clk); chk("rs2_unused", int'(ctrl), 6'b111100);
    cyc(); IFIDusesRs2 = 1;
    @(negedge clk); chk("rs2_used", int'(ctrl), 6'b001101);
    cyc(); branchTaken = 1;
    @(negedge clk); chk("br_lu_ctrl", int'(ctrl), 6'b111111);
    cyc(); branchTaken = 0; IDEXmemRead = 0;
    @(negedge clk); chk("br_flush", int'(flushCount), 1); chk("br_stall", int'(stallCount), 2);
    cyc(); rst_n = 0;
    @(negedge clk); chk("rst2_stall", int'(stallCount), 0); chk("rst2_flush", int'(flushCount), 0);
    cyc(); rst_n = 1; dmemReq = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mw_frozen", int'(ctrl), 0);
      cyc();
    end
    dmemReady = 1;
    @(negedge clk); chk("mw_last", int'(ctrl), 0);
    cyc(); dmemReq = 0; dmemReady = 0;
    @(negedge clk); chk("mw_run", int'(ctrl), 6'b111100); chk("mw_stall", int'(stallCount), 4);
    chk("mw_err", int'(memTimeoutErr), 0);
    cyc(); dmemReq = 1; dmemReady = 1;
    @(negedge clk); chk("zw_ctrl", int'(ctrl), 6'b111100);
    cyc(); dmemReq = 0; dmemReady = 0;
    @(negedge clk); chk("zw_stall", int'(stallCount), 4);
    cyc(); dmemReq = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); chk("to_err", int'(memTimeoutErr), i >= 5 ? 1 : 0);
      cyc();
    end
    dmemReady = 1;
    cyc(); dmemReq = 0; dmemReady = 0;
    @(negedge clk); chk("to_sticky", int'(memTimeoutErr), 1); chk("to_stall_sat", int'(stallCount), 15);
    cyc(); dmemReq = 1;
    cyc(); cyc(); rst_n = 0;
    @(negedge clk); chk("rmid_ctrl", int'(ctrl), 6'b111100); chk("rmid_stall", int'(stallCount), 0);
    chk("rmid_err", int'(memTimeoutErr), 0);
    cyc(); rst_n = 1; dmemReq = 0;
    @(negedge clk); chk("rmid_run", int'(ctrl), 6'b111100);
    IDEXmemRead = 1; IDEXrd = 3; IFIDrs1 = 3; IFIDusesRs2 = 0;
    repeat (20) cyc();
    IDEXmemRead = 0;
    @(negedge clk); chk("sat_stall", int'(stallCount), 15);
    branchTaken = 1;
    repeat (20) cyc();
    branchTaken = 0;
    @(negedge clk); chk("sat_flush", int'(flushCount), 15);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
